// File: rtl/fust_m_issue_if.sv
// FUST row / matrix FU issue bundle. The timeout signal exists only when FUST_M_TIMEOUT_EN is defined.
interface fust_m_issue_if #(
  parameter int unsigned MREG_W = 4
);
  logic              fust_busy;
  logic [MREG_W-1:0] fust_md;
  logic [MREG_W-1:0] fust_ms1;
  logic [MREG_W-1:0] fust_ms2;
  logic [MREG_W-1:0] fust_ms3;
  logic [2:0]        fust_rdy;
  logic              flush;
  logic              fu_valid;
  logic              fu_ready;
  logic [MREG_W-1:0] fu_md;
  logic [MREG_W-1:0] fu_ms1;
  logic [MREG_W-1:0] fu_ms2;
  logic [MREG_W-1:0] fu_ms3;
  logic              fu_done;
  // "release" is a reserved word, so the row-clear pulse is named row_release
  logic              row_release;
  logic [MREG_W-1:0] wb_md;
  logic              busy;
`ifdef FUST_M_TIMEOUT_EN
  logic              timeout;
`endif

  modport master (
`ifdef FUST_M_TIMEOUT_EN
    output timeout,
`endif
    input  fust_busy, fust_md, fust_ms1, fust_ms2, fust_ms3, fust_rdy, flush,
    input  fu_ready, fu_done,
    output fu_valid, fu_md, fu_ms1, fu_ms2, fu_ms3,
    output row_release, wb_md, busy
  );

  modport slave (
`ifdef FUST_M_TIMEOUT_EN
    input  timeout,
`endif
    output fust_busy, fust_md, fust_ms1, fust_ms2, fust_ms3, fust_rdy, flush,
    output fu_ready, fu_done,
    input  fu_valid, fu_md, fu_ms1, fu_ms2, fu_ms3,
    input  row_release, wb_md, busy
  );
endinterface

// File: rtl/fust_m_issue.sv
// Issue controller for one FUST matrix row: latch, wait operands, issue, execute, release.
// Optional EXEC watchdog enabled by defining FUST_M_TIMEOUT_EN.
module fust_m_issue #(
  parameter int unsigned MREG_W      = 4,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input logic           CLK,
  input logic           nRST,
  fust_m_issue_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_OPS,
    S_ISSUE,
    S_EXEC,
    S_RELEASE
  } state_e;

  state_e            state_q, state_d;
  logic [MREG_W-1:0] md_q, md_d;
  logic [MREG_W-1:0] ms1_q, ms1_d;
  logic [MREG_W-1:0] ms2_q, ms2_d;
  logic [MREG_W-1:0] ms3_q, ms3_d;
  logic              exec_expire;

`ifdef FUST_M_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // fu_done in the limit cycle wins over the watchdog
  assign exec_expire = (state_q == S_EXEC) && (cnt_q == CNT_LIM) && !bus.fu_done;
  assign bus.timeout = exec_expire;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_EXEC) begin
      cnt_d = cnt_q + 1'b1;
    end else if (state_d == S_EXEC) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign exec_expire = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    md_d    = md_q;
    ms1_d   = ms1_q;
    ms2_d   = ms2_q;
    ms3_d   = ms3_q;
    case (state_q)
      S_IDLE: begin
        if (bus.fust_busy && !bus.flush) begin
          md_d    = bus.fust_md;
          ms1_d   = bus.fust_ms1;
          ms2_d   = bus.fust_ms2;
          ms3_d   = bus.fust_ms3;
          state_d = S_WAIT_OPS;
        end
      end
      S_WAIT_OPS: begin
        if (bus.flush) begin
          state_d = S_IDLE;
        end else if (bus.fust_rdy == 3'b111) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bus.flush) begin
          state_d = S_IDLE;
        end else if (bus.fu_ready) begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (bus.fu_done || exec_expire) begin
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= S_IDLE;
      md_q    <= '0;
      ms1_q   <= '0;
      ms2_q   <= '0;
      ms3_q   <= '0;
    end else begin
      state_q <= state_d;
      md_q    <= md_d;
      ms1_q   <= ms1_d;
      ms2_q   <= ms2_d;
      ms3_q   <= ms3_d;
    end
  end

  assign bus.fu_valid    = (state_q == S_ISSUE);
  assign bus.fu_md       = bus.fu_valid ? md_q  : '0;
  assign bus.fu_ms1      = bus.fu_valid ? ms1_q : '0;
  assign bus.fu_ms2      = bus.fu_valid ? ms2_q : '0;
  assign bus.fu_ms3      = bus.fu_valid ? ms3_q : '0;
  assign bus.row_release = (state_q == S_RELEASE);
  assign bus.wb_md       = bus.row_release ? md_q : '0;
  assign bus.busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_fust_m_issue.sv
// Directed bench for fust_m_issue; watchdog scenario included when FUST_M_TIMEOUT_EN is defined.
module tb_fust_m_issue;

  logic CLK;
  logic nRST;
  int unsigned n_checks;
  int unsigned n_errors;

  fust_m_issue_if #(.MREG_W(4)) bus ();

  fust_m_issue #(
    .MREG_W      (4),
    .TIMEOUT_CYC (8)
  ) u_dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // advance one cycle; outputs are sampled 1 time unit after the rising edge
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // present a row for one cycle; returns in WAIT_OPS with fust_busy dropped
  task automatic start_op(input logic [3:0] md, input logic [3:0] s1,
                          input logic [3:0] s2, input logic [3:0] s3);
    bus.fust_busy = 1'b1;
    bus.fust_md   = md;
    bus.fust_ms1  = s1;
    bus.fust_ms2  = s2;
    bus.fust_ms3  = s3;
    step();
    bus.fust_busy = 1'b0;
    bus.fust_md   = 4'hF;
    bus.fust_ms1  = 4'hF;
    bus.fust_ms2  = 4'hF;
    bus.fust_ms3  = 4'hF;
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    nRST          = 1'b0;
    bus.fust_busy = 1'b0;
    bus.fust_md   = '0;
    bus.fust_ms1  = '0;
    bus.fust_ms2  = '0;
    bus.fust_ms3  = '0;
    bus.fust_rdy  = 3'b000;
    bus.flush     = 1'b0;
    bus.fu_ready  = 1'b0;
    bus.fu_done   = 1'b0;
    step();
    step();
    chk("rst_busy",  bus.busy,        0);
    chk("rst_valid", bus.fu_valid,    0);
    chk("rst_rel",   bus.row_release, 0);
    chk("rst_wbmd",  bus.wb_md,       0);
    chk("rst_fumd",  bus.fu_md,       0);
    nRST = 1'b1;

    // basic latency: busy at cycle 0, fu_valid at 2, done at 5, release at 6
    bus.fust_rdy = 3'b111;
    bus.fu_ready = 1'b1;
    start_op(4'd3, 4'd1, 4'd2, 4'd4);
    chk("c1_valid", bus.fu_valid, 0);
    chk("c1_busy",  bus.busy,     1);
    step();
    chk("c2_valid", bus.fu_valid, 1);
    chk("c2_md",    bus.fu_md,    3);
    chk("c2_ms1",   bus.fu_ms1,   1);
    chk("c2_ms2",   bus.fu_ms2,   2);
    chk("c2_ms3",   bus.fu_ms3,   4);
    step();
    chk("c3_valid", bus.fu_valid, 0);
    chk("c3_md",    bus.fu_md,    0);
    step();
    step();
    bus.fu_done = 1'b1;
    chk("c5_rel", bus.row_release, 0);
    step();
    bus.fu_done = 1'b0;
    chk("c6_rel",  bus.row_release, 1);
    chk("c6_wbmd", bus.wb_md,       3);
    step();
    chk("c7_rel",  bus.row_release, 0);
    chk("c7_wbmd", bus.wb_md,       0);
    chk("c7_busy", bus.busy,        0);

    // operands not ready for 4 cycles
    bus.fust_rdy = 3'b011;
    start_op(4'd5, 4'd6, 4'd7, 4'd8);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rdy_wait_valid", bus.fu_valid, 0);
    end
    bus.fust_rdy = 3'b111;
    chk("rdy_set_valid", bus.fu_valid, 0);
    step();
    chk("rdy_issue_valid", bus.fu_valid, 1);
    chk("rdy_issue_md",    bus.fu_md,    5);
    step();
    bus.fu_done = 1'b1;
    step();
    bus.fu_done = 1'b0;
    chk("rdy_rel",  bus.row_release, 1);
    chk("rdy_wbmd", bus.wb_md,       5);
    step();

    // backpressure for 3 ISSUE cycles; fu_done during ISSUE and handshake ignored
    bus.fu_ready = 1'b0;
    start_op(4'd9, 4'd3, 4'd5, 4'd7);
    step();
    bus.fu_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid", bus.fu_valid, 1);
      chk("bp_md",    bus.fu_md,    9);
      chk("bp_ms3",   bus.fu_ms3,   7);
      step();
    end
    chk("bp_still_valid", bus.fu_valid, 1);
    bus.fu_ready = 1'b1;
    step();
    bus.fu_done = 1'b0;
    chk("bp_exec_valid", bus.fu_valid,    0);
    chk("bp_exec_busy",  bus.busy,        1);
    chk("bp_exec_rel",   bus.row_release, 0);
    step();
    chk("bp_no_early_rel", bus.row_release, 0);
    bus.fu_done = 1'b1;
    step();
    bus.fu_done = 1'b0;
    chk("bp_rel",  bus.row_release, 1);
    chk("bp_wbmd", bus.wb_md,       9);
    step();

    // flush in ISSUE beats the same-cycle handshake
    start_op(4'd6, 4'd1, 4'd1, 4'd1);
    step();
    chk("fl_issue_valid", bus.fu_valid, 1);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("fl_issue_busy",  bus.busy,     0);
    chk("fl_issue_valid0", bus.fu_valid, 0);
    step();
    chk("fl_issue_norel", bus.row_release, 0);

    // flush in WAIT_OPS and in IDLE
    bus.fust_rdy = 3'b000;
    start_op(4'd2, 4'd2, 4'd2, 4'd2);
    bus.flush = 1'b1;
    step();
    chk("fl_wait_busy", bus.busy, 0);
    bus.fust_busy = 1'b1;
    step();
    bus.fust_busy = 1'b0;
    bus.flush     = 1'b0;
    chk("fl_idle_busy", bus.busy, 0);
    bus.fust_rdy = 3'b111;

    // flush in EXEC is ignored
    start_op(4'hA, 4'd1, 4'd2, 4'd3);
    step();
    step();
    bus.flush = 1'b1;
    step();
    chk("fl_exec_busy", bus.busy, 1);
    bus.fu_done = 1'b1;
    step();
    bus.fu_done = 1'b0;
    bus.flush   = 1'b0;
    chk("fl_exec_rel",  bus.row_release, 1);
    chk("fl_exec_wbmd", bus.wb_md,       4'hA);
    step();

    // reset in EXEC aborts without release
    start_op(4'hC, 4'd1, 4'd2, 4'd3);
    step();
    step();
    chk("rx_exec_busy", bus.busy, 1);
    nRST = 1'b0;
    step();
    nRST = 1'b1;
    chk("rx_busy",  bus.busy,        0);
    chk("rx_valid", bus.fu_valid,    0);
    chk("rx_rel",   bus.row_release, 0);
    chk("rx_wbmd",  bus.wb_md,       0);
    bus.fu_done = 1'b1;
    step();
    bus.fu_done = 1'b0;
    chk("rx_late_rel", bus.row_release, 0);
    chk("rx_late_busy", bus.busy,       0);

`ifdef FUST_M_TIMEOUT_EN
    // watchdog fires in EXEC cycle 8
    start_op(4'hD, 4'd1, 4'd2, 4'd3);
    step();
    step();
    for (int i = 1; i < 8; i++) begin
      chk("to_quiet", bus.timeout, 0);
      step();
    end
    chk("to_pulse", bus.timeout, 1);
    step();
    chk("to_rel",   bus.row_release, 1);
    chk("to_wbmd",  bus.wb_md,       4'hD);
    chk("to_clear", bus.timeout,     0);
    step();

    // fu_done in the limit cycle wins
    start_op(4'hE, 4'd1, 4'd2, 4'd3);
    step();
    step();
    for (int i = 1; i < 8; i++) step();
    bus.fu_done = 1'b1;
    #1;
    chk("to_done_wins", bus.timeout, 0);
    step();
    bus.fu_done = 1'b0;
    chk("to_done_rel",  bus.row_release, 1);
    chk("to_done_wbmd", bus.wb_md,       4'hE);
    step();
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fust_m_issue.md
FUST_M_ISSUE -- requirements
Module: fust_m_issue

Interface
REQ-001 SHALL have parameter MREG_W, default 4, matrix register tag width.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 64, watchdog limit in cycles; used only when FUST_M_TIMEOUT_EN is defined.
REQ-003 SHALL have port CLK  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port nRST  input  1  reset; synchronous, active-low.
REQ-005 SHALL have port fust_busy  input  1  FUST matrix row holds a valid instruction.
REQ-006 SHALL have port fust_md  input  MREG_W  destination matrix register tag.
REQ-007 SHALL have ports fust_ms1, fust_ms2, fust_ms3  input  MREG_W each  source tags A, B, C.
REQ-008 SHALL have port fust_rdy  input  3  per-source operand ready bits, bit0=ms1.
REQ-009 SHALL have port flush  input  1  squash request from the scoreboard.
REQ-010 SHALL have port fu_valid  output  1  issue request to the matrix functional unit.
REQ-011 SHALL have port fu_ready  input  1  functional unit accepts the issue.
REQ-012 SHALL have ports fu_md, fu_ms1, fu_ms2, fu_ms3  output  MREG_W each  issued tags.
REQ-013 SHALL have port fu_done  input  1  functional unit completion pulse.
REQ-014 SHALL have port release  output  1  one-cycle pulse to clear the FUST row.
REQ-015 SHALL have port wb_md  output  MREG_W  tag retired with release.
REQ-016 SHALL have port busy  output  1  controller not in IDLE.
REQ-017 SHALL have port timeout  output  1  watchdog abort pulse; present only with FUST_M_TIMEOUT_EN.

Function
REQ-018 SHALL implement FSM states IDLE, WAIT_OPS, ISSUE, EXEC, RELEASE.
REQ-019 IDLE: when fust_busy=1 and flush=0, SHALL latch fust_md/ms1/ms2/ms3 and enter WAIT_OPS next cycle.
REQ-020 WAIT_OPS: when fust_rdy=3'b111, SHALL enter ISSUE next cycle; otherwise SHALL stay.
REQ-021 ISSUE: SHALL drive fu_valid=1 with fu_* equal to the latched tags, held stable until fu_valid&fu_ready; then SHALL enter EXEC next cycle.
REQ-022 fu_valid SHALL be 0 in every state other than ISSUE; fu_* SHALL be 0 when fu_valid=0.
REQ-023 EXEC: on fu_done=1, SHALL enter RELEASE next cycle.
REQ-024 RELEASE: SHALL drive release=1 and wb_md=latched md for exactly one cycle, then enter IDLE; wb_md SHALL be 0 otherwise.
REQ-025 Minimum latency SHALL be fust_busy rising (cycle 0, rdy all set, fu_ready=1) -> fu_valid at cycle 2; fu_done at cycle n -> release at cycle n+1.
REQ-026 flush=1 in IDLE, WAIT_OPS, or ISSUE SHALL force IDLE next cycle with no release; flush SHALL take priority over a same-cycle handshake.
REQ-027 flush in EXEC or RELEASE SHALL be ignored; the dispatched op SHALL complete and release.
REQ-028 fu_done outside EXEC, including in the handshake cycle, SHALL be ignored.
REQ-029 fust_busy dropping after the latch SHALL NOT affect progress; latched tags SHALL be used.
REQ-030 busy SHALL equal (state != IDLE).

Reset
REQ-031 nRST=0 at a rising CLK SHALL force IDLE and clear the latched tags and watchdog counter; all outputs SHALL be 0 the following cycle.
REQ-032 Reset mid-operation, including in EXEC, SHALL abort without release.

Configuration
REQ-033 With FUST_M_TIMEOUT_EN defined, a counter SHALL clear on EXEC entry and increment each EXEC cycle; on reaching TIMEOUT_CYC-1 with fu_done=0, SHALL pulse timeout=1 for one cycle and enter RELEASE.
REQ-034 With FUST_M_TIMEOUT_EN defined, fu_done in the limit cycle SHALL win, with timeout=0.
REQ-035 Without FUST_M_TIMEOUT_EN, the timeout port and counter SHALL be absent and EXEC SHALL wait indefinitely.

Verification
REQ-036 Cycle 0: fust_busy=1, md=3, ms=1/2/4, rdy=111, fu_ready=1 -> fu_valid=1 at cycle 2 with fu_md=3; fu_done at cycle 5 -> release=1, wb_md=3 at cycle 6 only.
REQ-037 rdy=011 for 4 cycles, then 111 -> fu_valid held 0 until the cycle after rdy=111.
REQ-038 fu_ready=0 for 3 ISSUE cycles -> fu_valid and tags stable, EXEC entered only after the handshake.
REQ-039 flush in ISSUE with fu_ready=1 -> IDLE, no release; flush in EXEC -> release still occurs after fu_done.
REQ-040 nRST=0 in EXEC -> next cycle busy=0, all outputs 0; a later fu_done produces no release.
REQ-041 FUST_M_TIMEOUT_EN with TIMEOUT_CYC=8 and no fu_done -> timeout pulse at EXEC cycle 8, release the next cycle.
